sort_collector: RTL and testbench
=================================

SORT_COLLECTOR -- requirements
Module: sort_collector

Interface
REQ-001 SHALL have parameter P_LOG, default 7, meaning log2 of the lane count N = 1<<P_LOG.
REQ-002 SHALL have parameter WIDTH, default 32, meaning bits per key.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port DIN  input  WIDTH  one key per cycle from the serial source.
REQ-006 SHALL have port DINEN  input  1  DIN is valid and is accepted this cycle.
REQ-007 SHALL have port FLUSH  input  1  close the current partial batch; present only with SORT_COLLECT_FLUSH_EN.
REQ-008 SHALL have port DOT  output  WIDTH<<P_LOG  assembled batch for the even-odd sorter's DIN; lane i is DOT[WIDTH*(i+1)-1:WIDTH*i].
REQ-009 SHALL have port DOTEN  output  1  one-cycle pulse marking DOT as a new batch; it drives the sorter's DINEN.
REQ-010 SHALL have port DOTCNT  output  P_LOG+1  count of real (non-pad) keys in DOT; present only with SORT_COLLECT_FLUSH_EN.

Function
REQ-011 SHALL always accept DINEN; there is no ready output and no backpressure.
REQ-012 SHALL write accepted keys into a fill buffer in arrival order: 1st key to lane 0, Nth key to lane N-1.
REQ-013 SHALL keep a fill counter cnt of range 0..N-1 that increments on each accepted key and wraps to 0 on the Nth key.
REQ-014 SHALL load the complete batch into a separate DOT register on the edge that accepts the Nth key, and SHALL assert DOTEN for exactly the following cycle.
REQ-015 SHALL hold DOT stable between DOTEN pulses; DOTEN SHALL be 0 at all other times.
REQ-016 SHALL accept key 0 of the next batch in the cycle DOTEN is high, so back-to-back batches need zero gap cycles; the sustained rate is one batch per N cycles.
REQ-017 SHALL leave cnt and the buffer unchanged in cycles where DINEN=0 (idle gaps of any length are allowed mid-batch).
REQ-018 SHALL use two states: FILL (cnt counts 0..N-1) and EMIT (DOTEN=1, lasts one cycle). EMIT always returns to FILL; data accepted during EMIT goes to the new batch.

Reset
REQ-019 SHALL, while RST=0 at a clock edge, set cnt=0, state=FILL, DOTEN=0, DOT=0, DOTCNT=0, and clear the fill buffer to 0.
REQ-020 SHALL discard a partial batch on reset mid-fill; no DOTEN is produced for it, and the first key after RST returns high goes to lane 0.
REQ-021 SHALL ignore DINEN and FLUSH while RST=0.

Configuration
REQ-022 SHALL compile FLUSH and DOTCNT only when the macro SORT_COLLECT_FLUSH_EN is defined.
REQ-023 With the macro defined, FLUSH with cnt>0 SHALL emit the batch with lanes cnt..N-1 set to all-ones, so pads sort to the top; DOTEN pulses next cycle and DOTCNT=cnt; then cnt=0.
REQ-024 With the macro defined, FLUSH and DINEN in the same cycle SHALL accept the key first and then pad the remaining lanes. If that key is the Nth, the block SHALL emit normally with DOTCNT=N and no extra batch.
REQ-025 With the macro defined, FLUSH with cnt=0 and DINEN=0 SHALL do nothing.
REQ-026 With the macro defined, a full batch SHALL report DOTCNT=N.
REQ-027 Without the macro, the FLUSH and DOTCNT ports SHALL be absent and a batch SHALL be emitted only when full.

Structure
REQ-028 SHALL take the P_LOG/WIDTH defaults and the pad constant (all-ones of WIDTH) from the shared sort package used by the sorter and its bench.
REQ-029 SHALL place the lane write-enable decode (cnt, DINEN to an N-bit one-hot) in one sub-module, lane_dec.

Verification
REQ-030 Bench SHALL check: P_LOG=7, WIDTH=32, keys 128,127,...,1 on consecutive cycles -> one DOTEN pulse the cycle after key 1, lane i = 128-i.
REQ-031 Bench SHALL check: two batches back-to-back with no gap -> DOTEN pulses exactly 128 cycles apart, and the second DOT is correct.
REQ-032 Bench SHALL check: P_LOG=2, keys 5,_,_,9,_,3,7 with gaps (_=DINEN low) -> a single DOTEN, DOT lanes {5,9,3,7}.
REQ-033 Bench SHALL check: P_LOG=2, keys 4,8, then RST low 1 cycle, then 1,2,3,4 -> no DOTEN before reset, then DOT={1,2,3,4}.
REQ-034 Bench SHALL check, with the macro: P_LOG=2, keys 6,2 then FLUSH -> DOT={6,2,FFFFFFFF,FFFFFFFF}, DOTCNT=2. Then FLUSH with cnt=0 -> no DOTEN.
REQ-035 Bench SHALL check, with the macro: P_LOG=2, keys 1,2,3, then key 4 with FLUSH in the same cycle -> exactly one DOTEN, DOT={1,2,3,4}, DOTCNT=4.
REQ-036 Bench SHALL check, end-to-end: the collector feeds the even-odd sorter with keys 128..1 -> sorter output lane i = i+1.

Source files
------------

// File: rtl/sort_collector_pkg.sv
// Shared sort definitions: default lane count / key width, pad key, collector states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sort_collector_pkg;

    localparam int P_LOG_DEF = 7;   // log2 of lane count
    localparam int WIDTH_DEF = 32;  // bits per key

    // Pad keys are all-ones so they sort to the top lanes of the sorter.
    localparam logic [WIDTH_DEF-1:0] PAD_KEY = '1;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/sort_collector_if.sv
// Serial key source -> collector -> sorter batch bus.
// Latency: n/a (signal bundle). Backpressure: none, DINEN is always accepted.
// Ports: DIN/DINEN/FLUSH toward the collector, DOT/DOTEN/DOTCNT out of it.
// FLUSH and DOTCNT exist only when SORT_COLLECT_FLUSH_EN is defined.
interface sort_collector_if
    import sort_collector_pkg::*;
#(
    parameter int P_LOG = P_LOG_DEF,
    parameter int WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0]          DIN;
    logic                      DINEN;
    logic [(WIDTH<<P_LOG)-1:0] DOT;
    logic                      DOTEN;
`ifdef SORT_COLLECT_FLUSH_EN
    logic                      FLUSH;
    logic [P_LOG:0]            DOTCNT;

    modport master (output DIN, DINEN, FLUSH, input DOT, DOTEN, DOTCNT);
    modport slave  (input DIN, DINEN, FLUSH, output DOT, DOTEN, DOTCNT);
`else
    modport master (output DIN, DINEN, input DOT, DOTEN);
    modport slave  (input DIN, DINEN, output DOT, DOTEN);
`endif

endinterface

// File: rtl/sort_collector_lane_dec.sv
// Lane write-enable decode: fill count plus key-valid to a one-hot lane strobe.
// Latency: combinational.
// Backpressure: none.
// Ports: cnt (next lane to fill), en (key valid), we (N-bit one-hot, all zero when en=0).
module lane_dec #(
    parameter int P_LOG = 7
) (
    input  logic [P_LOG-1:0]      cnt,
    input  logic                  en,
    output logic [(1<<P_LOG)-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[cnt] = 1'b1;
        end
    end

endmodule

// File: rtl/sort_collector.sv
// Collects serial keys into N-lane batches for the even-odd sorter.
// Latency: batch appears on DOT with a DOTEN pulse the cycle after the key that completes it.
// Backpressure: none; a key is accepted every cycle DINEN=1, including the DOTEN cycle.
// Ports: CLK, RST (sync active-low), bus (slave side of sort_collector_if).
// Optional SORT_COLLECT_FLUSH_EN adds FLUSH (pad and emit a partial batch) and DOTCNT.
module sort_collector
    import sort_collector_pkg::*;
#(
    parameter int P_LOG = P_LOG_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    sort_collector_if.slave bus
);

    localparam int N = 1 << P_LOG;

    state_t                    state;
    logic [P_LOG-1:0]          cnt;
    logic [N-1:0][WIDTH-1:0]   fill_q;
    logic [N-1:0][WIDTH-1:0]   fill_nxt;
    logic [N-1:0][WIDTH-1:0]   batch_nxt;
    logic [N-1:0][WIDTH-1:0]   dot_q;
    logic [N-1:0]              we;
    logic                      last_key;
    logic                      emit;

    lane_dec #(.P_LOG(P_LOG)) u_lane_dec (
        .cnt (cnt),
        .en  (bus.DINEN),
        .we  (we)
    );

    // cnt is all-ones exactly when the incoming key lands in lane N-1.
    assign last_key = bus.DINEN && (&cnt);

    // Buffer contents including this cycle's key, so the completing key can
    // go straight into DOT on the same edge that accepts it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            fill_nxt[i] = we[i] ? bus.DIN : fill_q[i];
        end
    end

`ifdef SORT_COLLECT_FLUSH_EN
    localparam int CW = P_LOG + 1;
    // The pad key is all-ones at any key width.
    localparam logic [WIDTH-1:0] PAD = {WIDTH{PAD_KEY[0]}};

    logic [P_LOG:0] keys_in;
    logic [P_LOG:0] dotcnt_q;

    // Real keys in the batch once this cycle's key (if any) is counted.
    // Equals N on a full batch, so the padding below never touches it.
    assign keys_in = {1'b0, cnt} + {{P_LOG{1'b0}}, bus.DINEN};
    assign emit    = last_key || (bus.FLUSH && (keys_in != '0));

    always_comb begin
        for (int i = 0; i < N; i++) begin
            batch_nxt[i] = (CW'(i) < keys_in) ? fill_nxt[i] : PAD;
        end
    end

    assign bus.DOTCNT = dotcnt_q;
`else
    assign emit      = last_key;
    assign batch_nxt = fill_nxt;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= FILL;
            cnt    <= '0;
            fill_q <= '0;
            dot_q  <= '0;
`ifdef SORT_COLLECT_FLUSH_EN
            dotcnt_q <= '0;
`endif
        end else begin
            // Keys are accepted identically in FILL and EMIT; by the EMIT
            // cycle cnt is already 0, so they start the next batch.
            fill_q <= fill_nxt;
            if (emit) begin
                cnt   <= '0;
                dot_q <= batch_nxt;
`ifdef SORT_COLLECT_FLUSH_EN
                dotcnt_q <= keys_in;
`endif
            end else if (bus.DINEN) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                FILL:    state <= emit ? EMIT : FILL;
                EMIT:    state <= emit ? EMIT : FILL;
                default: state <= FILL;
            endcase
        end
    end

    // The EMIT state bit is itself the registered one-cycle batch strobe.
    assign bus.DOTEN = (state == EMIT);
    assign bus.DOT   = dot_q;

endmodule

// File: tb/tb_sort_collector.sv
// Bench for sort_collector: a 128-lane and a 4-lane instance driven by directed steps,
// with expected batches queued at stimulus time and popped when DOTEN pulses.
// Optional SORT_COLLECT_FLUSH_EN adds the FLUSH/DOTCNT steps.
module tb_sort_collector;
    import sort_collector_pkg::*;

    localparam int BW = 32;
    localparam int BN = 128;
    localparam int SN = 4;

    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [BN*BW-1:0] exp_big_q[$];
    logic [SN*BW-1:0] exp_small_q[$];
    int               exp_small_cnt_q[$];
    int               pulses_big[$];
    int               n_pulse_small = 0;
    logic [BN*BW-1:0] mon_big_e;
    logic [SN*BW-1:0] mon_small_e;
    int               mon_small_c;

    sort_collector_if #(.P_LOG(7), .WIDTH(BW)) if_big ();
    sort_collector_if #(.P_LOG(2), .WIDTH(BW)) if_small ();

    sort_collector #(.P_LOG(7), .WIDTH(BW)) u_big (
        .CLK (CLK),
        .RST (RST),
        .bus (if_big.slave)
    );

    sort_collector #(.P_LOG(2), .WIDTH(BW)) u_small (
        .CLK (CLK),
        .RST (RST),
        .bus (if_small.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every DOTEN pulse must match the oldest queued batch.
    always @(negedge CLK) begin
        if (if_big.DOTEN === 1'b1) begin
            pulses_big.push_back(cyc);
            chk("big_pulse_expected", 128'(exp_big_q.size() != 0), 128'd1);
            if (exp_big_q.size() != 0) begin
                mon_big_e = exp_big_q.pop_front();
                for (int i = 0; i < BN; i++) begin
                    chk($sformatf("big_lane%0d", i), 128'(if_big.DOT[BW*i +: BW]),
                        128'(mon_big_e[BW*i +: BW]));
                end
`ifdef SORT_COLLECT_FLUSH_EN
                chk("big_dotcnt", 128'(if_big.DOTCNT), 128'd128);
`endif
            end
        end
    end

    always @(negedge CLK) begin
        if (if_small.DOTEN === 1'b1) begin
            n_pulse_small++;
            chk("small_pulse_expected", 128'(exp_small_q.size() != 0), 128'd1);
            if (exp_small_q.size() != 0) begin
                mon_small_e = exp_small_q.pop_front();
                mon_small_c = exp_small_cnt_q.pop_front();
                chk("small_dot", 128'(if_small.DOT), 128'(mon_small_e));
`ifdef SORT_COLLECT_FLUSH_EN
                chk("small_dotcnt", 128'(if_small.DOTCNT), 128'(mon_small_c));
`endif
            end
        end
    end

    task automatic big_step(input logic en, input logic [BW-1:0] k);
        if_big.DINEN = en;
        if_big.DIN   = k;
        @(posedge CLK);
        #1;
    endtask

    task automatic small_step(input logic en, input logic [BW-1:0] k);
        if_small.DINEN = en;
        if_small.DIN   = k;
        @(posedge CLK);
        #1;
        if_small.DINEN = 1'b0;
    endtask

`ifdef SORT_COLLECT_FLUSH_EN
    task automatic small_flush(input logic en, input logic [BW-1:0] k);
        if_small.DINEN = en;
        if_small.DIN   = k;
        if_small.FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        if_small.DINEN = 1'b0;
        if_small.FLUSH = 1'b0;
    endtask
`endif

    task automatic idle(input int n);
        if_big.DINEN   = 1'b0;
        if_small.DINEN = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Behavioural even-odd transposition sorter fed by the big collector's DOT.
    task automatic sorter_check();
        logic [BW-1:0] a [BN];
        logic [BW-1:0] t;
        for (int i = 0; i < BN; i++) a[i] = if_big.DOT[BW*i +: BW];
        for (int r = 0; r < BN; r++) begin
            for (int i = r % 2; i < BN - 1; i += 2) begin
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
            end
        end
        for (int i = 0; i < BN; i++) begin
            chk($sformatf("e2e_sorted_lane%0d", i), 128'(a[i]), 128'(i + 1));
        end
    endtask

    initial begin
        logic [BN*BW-1:0] eb;
        int last_key_cyc;
        int exp_small_pulses;

        exp_small_pulses = 0;
        RST            = 1'b0;
        if_big.DIN     = '0;
        if_big.DINEN   = 1'b0;
        if_small.DIN   = '0;
        if_small.DINEN = 1'b0;
`ifdef SORT_COLLECT_FLUSH_EN
        if_big.FLUSH   = 1'b0;
        if_small.FLUSH = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        chk("rst_big_doten", 128'(if_big.DOTEN), 128'd0);
        chk("rst_big_dot_zero", 128'(|if_big.DOT), 128'd0);
        chk("rst_small_doten", 128'(if_small.DOTEN), 128'd0);
        chk("rst_small_dot", 128'(if_small.DOT), 128'd0);
`ifdef SORT_COLLECT_FLUSH_EN
        chk("rst_small_dotcnt", 128'(if_small.DOTCNT), 128'd0);
`endif
        RST = 1'b1;

        // Keys 128..1 on consecutive cycles: lane i = 128-i
        for (int i = 0; i < BN; i++) eb[BW*i +: BW] = BW'(128 - i);
        exp_big_q.push_back(eb);
        for (int k = 128; k >= 1; k--) big_step(1'b1, BW'(k));
        last_key_cyc = cyc;
        idle(5);
        chk("big_first_pulse_count", 128'(pulses_big.size()), 128'd1);
        if (pulses_big.size() >= 1)
            chk("big_pulse_after_last_key", 128'(pulses_big[0]), 128'(last_key_cyc));
        // DOT held since the pulse; sorted it must be 1..128
        sorter_check();

        // Two back-to-back batches, no gap
        for (int i = 0; i < BN; i++) eb[BW*i +: BW] = BW'(7 * i + 3);
        exp_big_q.push_back(eb);
        for (int i = 0; i < BN; i++) eb[BW*i +: BW] = BW'(4000 - 11 * i);
        exp_big_q.push_back(eb);
        for (int i = 0; i < BN; i++) big_step(1'b1, BW'(7 * i + 3));
        for (int i = 0; i < BN; i++) big_step(1'b1, BW'(4000 - 11 * i));
        idle(4);
        chk("big_total_pulses", 128'(pulses_big.size()), 128'd3);
        if (pulses_big.size() >= 3)
            chk("big_b2b_spacing", 128'(pulses_big[2] - pulses_big[1]), 128'd128);

        // 4-lane: keys with idle gaps
        exp_small_q.push_back({32'd7, 32'd3, 32'd9, 32'd5});
        exp_small_cnt_q.push_back(4);
        exp_small_pulses++;
        small_step(1'b1, 32'd5);
        idle(2);
        small_step(1'b1, 32'd9);
        idle(1);
        small_step(1'b1, 32'd3);
        small_step(1'b1, 32'd7);
        idle(3);
        chk("small_gap_pulses", 128'(n_pulse_small), 128'(exp_small_pulses));

        // Partial batch discarded by reset, next key goes to lane 0
        small_step(1'b1, 32'd4);
        small_step(1'b1, 32'd8);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        chk("small_mid_reset_dot", 128'(if_small.DOT), 128'd0);
        chk("small_mid_reset_doten", 128'(if_small.DOTEN), 128'd0);
        exp_small_q.push_back({32'd4, 32'd3, 32'd2, 32'd1});
        exp_small_cnt_q.push_back(4);
        exp_small_pulses++;
        for (int k = 1; k <= 4; k++) small_step(1'b1, BW'(k));
        idle(3);
        chk("small_after_reset_pulses", 128'(n_pulse_small), 128'(exp_small_pulses));

`ifdef SORT_COLLECT_FLUSH_EN
        // Flush of a 2-key batch pads the top lanes
        exp_small_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd6});
        exp_small_cnt_q.push_back(2);
        exp_small_pulses++;
        small_step(1'b1, 32'd6);
        small_step(1'b1, 32'd2);
        small_flush(1'b0, 32'd0);
        idle(2);
        // Flush with an empty batch does nothing
        small_flush(1'b0, 32'd0);
        idle(3);
        chk("small_flush_pulses", 128'(n_pulse_small), 128'(exp_small_pulses));

        // Flush together with the Nth key: one normal batch
        exp_small_q.push_back({32'd4, 32'd3, 32'd2, 32'd1});
        exp_small_cnt_q.push_back(4);
        exp_small_pulses++;
        small_step(1'b1, 32'd1);
        small_step(1'b1, 32'd2);
        small_step(1'b1, 32'd3);
        small_flush(1'b1, 32'd4);
        idle(3);
        chk("small_flush_nth_pulses", 128'(n_pulse_small), 128'(exp_small_pulses));

        // Flush together with a non-final key: key taken, rest padded
        exp_small_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10, 32'd9});
        exp_small_cnt_q.push_back(2);
        exp_small_pulses++;
        small_step(1'b1, 32'd9);
        small_flush(1'b1, 32'd10);
        idle(3);
        chk("small_flush_key_pulses", 128'(n_pulse_small), 128'(exp_small_pulses));
`endif

        chk("big_queue_drained", 128'(exp_big_q.size()), 128'd0);
        chk("small_queue_drained", 128'(exp_small_q.size()), 128'd0);
        chk("big_final_pulses", 128'(pulses_big.size()), 128'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
